// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: bundles the core-side load/store signals and the memory-side
// request/response channel of the data-memory controller.
//
//   Core side   : memread, memwrite, addr, wdata -> controller
//                 rdata, stall, err               <- controller
//   Memory side : mem_req, mem_we, mem_addr, mem_wdata <- controller
//                 mem_ready, mem_rvalid, mem_rdata     -> controller
//
// Modports:
//   master : the controller (masters the memory channel, serves the core).
//   slave  : the environment (core pipeline plus memory) around the controller.
interface dmem_ctrl_if;
    // Core side
    logic        memread;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        err;
    // Memory side
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        input  memread, memwrite, addr, wdata,
        input  mem_ready, mem_rvalid, mem_rdata,
        output rdata, stall, err,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output memread, memwrite, addr, wdata,
        output mem_ready, mem_rvalid, mem_rdata,
        input  rdata, stall, err,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory access controller sitting between a core's load/store
// stage and a request/ready/rvalid memory port. One access is in flight at a
// time; the core is stalled until the access completes or is aborted.
//
// Ports:
//   clk   : sole clock, all state changes on the rising edge.
//   reset : synchronous, active-high reset.
//   bus   : dmem_ctrl_if.master
//           core side  - memread/memwrite/addr/wdata in, rdata/stall/err out
//           memory side - mem_req/mem_we/mem_addr/mem_wdata out,
//                         mem_ready/mem_rvalid/mem_rdata in
//
// Parameter:
//   TIMEOUT : number of cycles an access may spend waiting for the memory
//             (request plus response phases combined) before it is aborted.
//
// Behaviour overview:
//   Idle   - a single, word-aligned load or store is latched and issued.
//            Misaligned or simultaneous load+store requests go straight to
//            Done with err set and rdata cleared, without touching memory.
//   Req    - mem_req held high with stable fields until mem_ready.
//            Stores are posted (done at the handshake). Loads finish at the
//            handshake if mem_rvalid arrives in the same cycle, else wait.
//   WaitR  - waits for mem_rvalid and captures mem_rdata.
//   Done   - one cycle, stall low, err reflects an aborted access.
module dmem_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    dmem_ctrl_if.master  bus
);

    // Wait counter only has to reach TIMEOUT-1.
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWaitR,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              core_req;
    logic              bad_req;
    logic              timed_out;
    logic              abort;

    assign core_req  = bus.memread | bus.memwrite;
    // Conflicting or misaligned requests never reach the memory.
    assign bad_req   = (bus.memread & bus.memwrite) | (bus.addr[1:0] != 2'b00);
    assign timed_out = (cnt_q == CntMax);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        err_d       = 1'b0;
        abort       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (core_req) begin
                    if (bad_req) begin
                        abort = 1'b1;
                    end else begin
                        state_d    = StReq;
                        cnt_d      = '0;
                        mem_req_d  = 1'b1;
                        mem_we_d   = bus.memwrite;
                        mem_addr_d = bus.addr;
                        // Loads leave the previous store data in place.
                        if (bus.memwrite) begin
                            mem_wdata_d = bus.wdata;
                        end
                    end
                end
            end

            StReq: begin
                if (bus.mem_ready) begin
                    if (mem_we_q) begin
                        // Posted write: nothing comes back.
                        state_d   = StDone;
                        mem_req_d = 1'b0;
                    end else if (bus.mem_rvalid) begin
                        state_d   = StDone;
                        mem_req_d = 1'b0;
                        rdata_d   = bus.mem_rdata;
                    end else if (timed_out) begin
                        // Accepted but the response would land past the budget.
                        abort = 1'b1;
                    end else begin
                        state_d   = StWaitR;
                        mem_req_d = 1'b0;
                        cnt_d     = cnt_q + CntW'(1);
                    end
                end else if (timed_out) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StWaitR: begin
                if (bus.mem_rvalid) begin
                    state_d = StDone;
                    rdata_d = bus.mem_rdata;
                end else if (timed_out) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StDone: begin
                // Core inputs are ignored here; the core sees stall low and
                // retires the instruction this cycle.
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        if (abort) begin
            state_d   = StDone;
            mem_req_d = 1'b0;
            rdata_d   = '0;
            err_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // stall is combinational so the core freezes in the very cycle it asks.
    assign bus.stall = ~reset & (((state_q == StIdle) & core_req) |
                                 (state_q == StReq) | (state_q == StWaitR));

    assign bus.rdata     = rdata_q;
    assign bus.err       = err_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: self-checking bench for dmem_ctrl. Directed vectors and random
// transactions are both expressed as {request, memory timing, expected result}
// records; expectations for random ones come from a transaction-level model.
module tb_dmem_ctrl;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned NumVec  = 14;
    localparam int unsigned NumRand = 60;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_ctrl_if bus ();

    dmem_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] data;       // load response value
        int unsigned rdy_dly;    // cycles in Req before mem_ready
        int unsigned rsp_dly;    // cycles after the handshake before mem_rvalid
        int unsigned exp_stall;  // cycles with stall high, Idle cycle included
        int unsigned exp_req;    // cycles with mem_req high
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Expected memory-side fields and rdata carried across transactions.
    logic [31:0] sh_addr, sh_wdata, model_rdata;
    logic        sh_we;

    vec_t tbl [NumVec];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] data,
                                input int unsigned rdy, input int unsigned rsp,
                                input int unsigned st, input int unsigned rq,
                                input logic er, input logic [31:0] rdat);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.data = data;
        v.rdy_dly = rdy; v.rsp_dly = rsp;
        v.exp_stall = st; v.exp_req = rq; v.exp_err = er; v.exp_rdata = rdat;
        return v;
    endfunction

    // Transaction-level reference: when does the access finish, and how.
    function automatic vec_t predict(input vec_t v, input logic [31:0] prev_rdata);
        vec_t        e;
        int unsigned finish;
        e = v;
        if ((v.rd && v.wr) || (v.addr[1:0] != 2'b00)) begin
            e.exp_stall = 1; e.exp_req = 0; e.exp_err = 1'b1; e.exp_rdata = '0;
        end else begin
            finish = v.wr ? v.rdy_dly : v.rdy_dly + v.rsp_dly;
            if (finish < TIMEOUT) begin
                e.exp_stall = finish + 2;
                e.exp_req   = v.rdy_dly + 1;
                e.exp_err   = 1'b0;
                e.exp_rdata = v.wr ? prev_rdata : v.data;
            end else begin
                e.exp_stall = TIMEOUT + 1;
                e.exp_req   = ((v.rdy_dly < TIMEOUT) ? v.rdy_dly : TIMEOUT - 1) + 1;
                e.exp_err   = 1'b1;
                e.exp_rdata = '0;
            end
        end
        return e;
    endfunction

    task automatic run_txn(input vec_t v, input bit noise);
        int unsigned stall_cnt, req_cnt, unstable, i;
        bit          done, bad;
        stall_cnt = 0; req_cnt = 0; unstable = 0; done = 1'b0;
        bad = (v.rd && v.wr) || (v.addr[1:0] != 2'b00);

        @(negedge clk);
        bus.memread = v.rd; bus.memwrite = v.wr; bus.addr = v.addr; bus.wdata = v.wdata;
        bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = $urandom;
        #1;
        if (bus.stall) stall_cnt++;
        if (bus.mem_req) req_cnt++;

        for (int c = 1; c <= 3 * TIMEOUT && !done; c++) begin
            i = c - 1;
            @(negedge clk);
            bus.mem_ready  = (i == v.rdy_dly);
            bus.mem_rvalid = v.rd && !v.wr &&
                             ((i == v.rdy_dly + v.rsp_dly) ||
                              (noise && i < v.rdy_dly && $urandom_range(0, 1) == 1));
            bus.mem_rdata  = (i == v.rdy_dly + v.rsp_dly) ? v.data : $urandom;
            #1;
            if (bus.mem_req) begin
                req_cnt++;
                if (bus.mem_addr !== v.addr || bus.mem_we !== v.wr ||
                    (v.wr && bus.mem_wdata !== v.wdata)) unstable++;
            end
            if (bus.stall) stall_cnt++;
            else done = 1'b1;
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL txn_bound: stall still high after %0d cycles, expected Done",
                     3 * TIMEOUT);
        end

        // Now in Done.
        check32("stall_cycles", stall_cnt, v.exp_stall);
        check32("mem_req_cycles", req_cnt, v.exp_req);
        check32("req_fields_unstable", unstable, 0);
        check32("err_in_done", bus.err, v.exp_err);
        check32("rdata_in_done", bus.rdata, v.exp_rdata);
        if (!bad) begin
            sh_addr = v.addr;
            sh_we   = v.wr;
            if (v.wr) sh_wdata = v.wdata;
        end
        model_rdata = v.exp_rdata;
        check32("mem_addr_held", bus.mem_addr, sh_addr);
        check32("mem_we_held", bus.mem_we, sh_we);
        check32("mem_wdata_held", bus.mem_wdata, sh_wdata);
        bus.memread = 1'b0; bus.memwrite = 1'b0;
        bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0;

        // Idle with a stray/late response that must be ignored.
        @(negedge clk);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = $urandom;
        #1;
        check32("idle_stall", bus.stall, 1'b0);
        check32("err_pulse_end", bus.err, 1'b0);
        check32("idle_mem_req", bus.mem_req, 1'b0);
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        #1;
        check32("rdata_after_stray", bus.rdata, model_rdata);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        v;
        int unsigned k;

        // Directed vectors, expectations derived by hand.
        tbl[0]  = mk(0, 1, 32'h100, 32'hA5A5A5A5, 32'h0,        2,  0,  4,  3, 0, 32'h0);
        tbl[1]  = mk(1, 0, 32'h200, 32'h0,        32'h12345678, 0,  3,  5,  1, 0, 32'h12345678);
        tbl[2]  = mk(1, 0, 32'h400, 32'h0,        32'h55555555, 99, 0,  17, 16, 1, 32'h0);
        tbl[3]  = mk(1, 0, 32'h204, 32'h0,        32'hCAFEF00D, 0,  0,  2,  1, 0, 32'hCAFEF00D);
        tbl[4]  = mk(1, 0, 32'h203, 32'h0,        32'h0,        0,  0,  1,  0, 1, 32'h0);
        tbl[5]  = mk(1, 0, 32'h208, 32'h0,        32'hDEADBEEF, 2,  1,  5,  3, 0, 32'hDEADBEEF);
        tbl[6]  = mk(1, 1, 32'h300, 32'h1,        32'h0,        0,  0,  1,  0, 1, 32'h0);
        tbl[7]  = mk(1, 0, 32'h20C, 32'h0,        32'h11112222, 0,  0,  2,  1, 0, 32'h11112222);
        tbl[8]  = mk(0, 1, 32'h210, 32'h0BADCAFE, 32'h0,        0,  0,  2,  1, 0, 32'h11112222);
        tbl[9]  = mk(1, 0, 32'h214, 32'h0,        32'h0F0F0F0F, 0,  15, 17, 1, 0, 32'h0F0F0F0F);
        tbl[10] = mk(0, 1, 32'h218, 32'h600DF00D, 32'h0,        15, 0,  17, 16, 0, 32'h0F0F0F0F);
        tbl[11] = mk(1, 0, 32'h220, 32'h0,        32'h77777777, 3,  20, 17, 4, 1, 32'h0);
        tbl[12] = mk(0, 1, 32'h21C, 32'h12121212, 32'h0,        16, 0,  17, 16, 1, 32'h0);
        tbl[13] = mk(1, 0, 32'h224, 32'h0,        32'h88888888, 15, 1,  17, 16, 1, 32'h0);

        bus.memread = 1'b0; bus.memwrite = 1'b0; bus.addr = '0; bus.wdata = '0;
        bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        reset = 1'b1;

        // Reset: stall stays low even with a request pending.
        @(negedge clk);
        bus.memread = 1'b1;
        @(negedge clk);
        #1;
        check32("stall_in_reset", bus.stall, 1'b0);
        bus.memread = 1'b0;
        reset = 1'b0;
        #1;
        check32("rst_mem_req", bus.mem_req, 1'b0);
        check32("rst_mem_we", bus.mem_we, 1'b0);
        check32("rst_mem_addr", bus.mem_addr, 32'h0);
        check32("rst_mem_wdata", bus.mem_wdata, 32'h0);
        check32("rst_rdata", bus.rdata, 32'h0);
        check32("rst_err", bus.err, 1'b0);
        sh_addr = '0; sh_we = 1'b0; sh_wdata = '0; model_rdata = '0;

        for (int n = 0; n < NumVec; n++) run_txn(tbl[n], 1'b0);

        // No request: nothing moves while the address bus wanders.
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            bus.addr = $urandom; bus.wdata = $urandom;
            #1;
            check32("noreq_stall", bus.stall, 1'b0);
            check32("noreq_mem_req", bus.mem_req, 1'b0);
            check32("noreq_mem_addr", bus.mem_addr, sh_addr);
        end

        // Reset while waiting for a load response.
        run_txn(mk(1, 0, 32'h30, 32'h0, 32'h13572468, 0, 0, 2, 1, 0, 32'h13572468), 1'b0);
        @(negedge clk);
        bus.memread = 1'b1; bus.addr = 32'h300;
        @(negedge clk);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        check32("waitr_stall", bus.stall, 1'b1);
        check32("waitr_mem_req", bus.mem_req, 1'b0);
        reset = 1'b1;
        #1;
        check32("stall_reset_waitr", bus.stall, 1'b0);
        @(negedge clk);
        reset = 1'b0; bus.memread = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h99999999;
        #1;
        check32("rstw_stall", bus.stall, 1'b0);
        check32("rstw_mem_req", bus.mem_req, 1'b0);
        check32("rstw_err", bus.err, 1'b0);
        check32("rstw_rdata", bus.rdata, 32'h0);
        check32("rstw_mem_addr", bus.mem_addr, 32'h0);
        check32("rstw_mem_we", bus.mem_we, 1'b0);
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        #1;
        check32("rstw_stray_rdata", bus.rdata, 32'h0);
        sh_addr = '0; sh_we = 1'b0; sh_wdata = '0; model_rdata = '0;

        // Random transactions against the model.
        for (int n = 0; n < NumRand; n++) begin
            k = $urandom_range(0, 9);
            v.rd = (k <= 5); v.wr = (k == 0) || (k >= 6);
            v.addr = $urandom;
            if ($urandom_range(0, 9) < 8) v.addr[1:0] = 2'b00;
            v.wdata = $urandom; v.data = $urandom;
            v.rdy_dly = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 6);
            v.rsp_dly = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 16) : $urandom_range(0, 5);
            v = predict(v, model_rdata);
            run_txn(v, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, max cycles an access may wait in REQ or WAIT_R before abort.
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port memread  input  1  core load request for current instruction.
REQ-005 Port memwrite  input  1  core store request for current instruction.
REQ-006 Port addr  input  32  byte address from core ALU result.
REQ-007 Port wdata  input  32  store data from core register file.
REQ-008 Port rdata  output  32  load data returned to core result mux.
REQ-009 Port stall  output  1  freeze PC and register-file write while high.
REQ-010 Port err  output  1  one-cycle pulse: access aborted (misaligned, conflicting, or timeout).
REQ-011 Port mem_req  output  1  request valid toward memory.
REQ-012 Port mem_we  output  1  1 = store, 0 = load; valid with mem_req.
REQ-013 Port mem_addr  output  32  word-aligned address; valid with mem_req.
REQ-014 Port mem_wdata  output  32  store data; valid with mem_req and mem_we.
REQ-015 Port mem_ready  input  1  memory accepts request this cycle.
REQ-016 Port mem_rvalid  input  1  load data valid this cycle.
REQ-017 Port mem_rdata  input  32  load data.

Function
REQ-018 States SHALL be IDLE, REQ, WAIT_R, DONE; one access in flight max.
REQ-019 stall SHALL be combinational: high in IDLE when memread|memwrite, high in REQ and WAIT_R, low in DONE and during reset.
REQ-020 IDLE, exactly one of memread/memwrite, addr[1:0]==0 -> REQ; latch mem_addr=addr, mem_we=memwrite, mem_wdata=wdata (store) on that edge.
REQ-021 IDLE, addr[1:0]!=0 or memread&memwrite -> DONE without mem_req; rdata=0; err=1 during DONE.
REQ-022 mem_req SHALL be high throughout REQ; mem_addr, mem_we, mem_wdata SHALL hold stable until handshake (mem_req&mem_ready).
REQ-023 REQ, handshake, store -> DONE; no response expected (posted write).
REQ-024 REQ, handshake, load, mem_rvalid low -> WAIT_R.
REQ-025 REQ, handshake, load, mem_rvalid high same cycle -> DONE; rdata captured from mem_rdata.
REQ-026 WAIT_R, mem_rvalid -> DONE; rdata=mem_rdata captured on that edge.
REQ-027 mem_rvalid outside WAIT_R (or REQ handshake cycle of a load) SHALL be ignored.
REQ-028 Wait counter SHALL clear on entry to REQ, increment each cycle in REQ/WAIT_R, not reset between REQ and WAIT_R.
REQ-029 Counter reaching TIMEOUT-1 without completing -> DONE, mem_req low, rdata=0, err=1 in DONE; late response ignored.
REQ-030 DONE SHALL last exactly one cycle, ignore memread/memwrite, then -> IDLE; rdata held until next capture.
REQ-031 err SHALL be high only in DONE entered via abort path; low otherwise.
REQ-032 No request when memread=memwrite=0 in IDLE: stay IDLE, stall low, outputs unchanged.

Reset
REQ-033 reset high at a rising edge SHALL force state IDLE, counter 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, rdata 0, err 0.
REQ-034 Reset mid-access (REQ or WAIT_R) SHALL drop mem_req on the next edge and discard any subsequent mem_rvalid.

Verification
REQ-035 Store addr=0x100, wdata=0xA5A5A5A5, mem_ready after 2 cycles -> mem_req 3 cycles, fields stable, DONE 1 cycle, stall low in DONE, err 0.
REQ-036 Load addr=0x200, mem_ready immediate, mem_rvalid 3 cycles later with 0x12345678 -> rdata=0x12345678 in DONE, stall high 5 cycles total.
REQ-037 Load with mem_ready and mem_rvalid same cycle, data 0xCAFEF00D -> REQ->DONE directly, rdata=0xCAFEF00D.
REQ-038 Load addr=0x203 -> no mem_req, err pulse 1 cycle, rdata=0; memread&memwrite both high -> same.
REQ-039 TIMEOUT=16, mem_ready never high -> abort after 16 cycles, err pulse, rdata=0; late mem_rvalid ignored.
REQ-040 reset asserted in WAIT_R -> IDLE next edge, all outputs at reset values, stray mem_rvalid afterwards leaves rdata=0.
